ctrl_decode_stage: RTL
======================

CTRL_DECODE_STAGE -- requirements
Module: ctrl_decode_stage

Interface
REQ-001 SHALL have parameter: DSP_TIMEOUT, default 64, max DSP_WAIT cycles before abort.
REQ-002 SHALL have parameter: RD_W, default 5, register-address width.
REQ-003 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-004 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports: instr_valid  in  1  instr holds a valid instruction.
REQ-006 SHALL have ports: instr  in  32  instruction word; opcode=[6:0], rd=[11:7], rs1=[19:15], rs2=[24:20].
REQ-007 SHALL have ports: flush  in  1  branch-taken kill from EX.
REQ-008 SHALL have ports: ex_memread  in  1  and  ex_rd  in  RD_W  load in EX and its destination.
REQ-009 SHALL have ports: dsp_done  in  1  DSP completion pulse.
REQ-010 SHALL have ports: dsp_start  out  1  DSP launch pulse.
REQ-011 SHALL have ports: stall  out  1  hold PC/IF-ID (combinational).
REQ-012 SHALL have ports: out_valid, out_regwrite, out_alusrc, out_memwrite, out_memread, out_branch, out_memtoreg, out_illegal  out  1 each; out_aluop  out  3; out_rd  out  RD_W; all registered ID/EX controls.

Function
REQ-013 SHALL decode: 0110011 -> regwrite, aluop 010; 0010011 -> regwrite, alusrc, aluop 011; 0000011 -> regwrite, alusrc, memread, memtoreg, aluop 000; 0100011 -> alusrc, memwrite, aluop 000; 1100011 -> branch, aluop 001; 1010111 -> vector, aluop 100.
REQ-014 SHALL register scalar decode with 1-cycle latency: instr_valid at cycle N -> out_* valid at N+1.
REQ-015 SHALL treat any other opcode as illegal: out_valid=1, out_illegal=1, all other controls 0, out_rd=0.
REQ-016 SHALL raise load-use hazard when instr_valid & ex_memread & ex_rd!=0 & (ex_rd==rs1 | (ex_rd==rs2 & opcode in {R,S,B})).
REQ-017 SHALL on hazard assert stall same cycle and emit bubble (out_valid=0, all controls 0) next cycle.
REQ-018 SHALL on flush emit bubble next cycle and return FSM to IDLE; flush overrides hazard, decode and dsp_done in same cycle.
REQ-019 SHALL implement FSM IDLE -> DSP_START -> DSP_WAIT -> IDLE.
REQ-020 SHALL transition IDLE->DSP_START on valid vector instr without hazard/flush; dsp_start=1 exactly one cycle (DSP_START); stall=1 throughout DSP_START/DSP_WAIT.
REQ-021 SHALL on dsp_done in DSP_WAIT go IDLE and emit out_valid=1, out_regwrite=1, out_aluop=100, out_rd=latched rd next cycle.
REQ-022 SHALL count DSP_WAIT cycles in $clog2(DSP_TIMEOUT+1)-bit counter; at DSP_TIMEOUT without dsp_done -> IDLE, emit out_valid=1, out_illegal=1.
REQ-023 SHALL ignore dsp_done outside DSP_WAIT; dsp_done on the timeout cycle counts as completion.
REQ-024 SHALL emit bubbles while stalled in DSP_START/DSP_WAIT.

Reset
REQ-025 SHALL on rst clear all outputs to 0, FSM to IDLE, counter and latched rd to 0, immediately and regardless of clk.
REQ-026 SHALL abort an in-flight DSP op on mid-operation reset; no completion emitted.

Configuration
REQ-027 SHALL with CTRL_DSP_EN defined implement REQ-019..024.
REQ-028 SHALL without CTRL_DSP_EN decode 1010111 as illegal, tie dsp_start=0, omit FSM and counter; stall driven by hazard only.

Structure
REQ-029 SHALL place opcode constants, aluop encodings, FSM state enum and control-bundle struct in package ctrl_pkg.
REQ-030 SHALL implement the opcode table as combinational sub-module ctrl_decode_comb.

Verification
REQ-031 SHALL cover: instr=0x00208033 (add) valid -> next cycle out_valid=1, regwrite=1, aluop=010, out_rd=0.
REQ-032 SHALL cover: ex_memread=1, ex_rd=2, instr add x3,x2,x1 -> stall=1 that cycle, bubble next; ex_rd=0 -> no stall.
REQ-033 SHALL cover: vector instr, dsp_done after 10 cycles -> dsp_start one-cycle pulse, stall=1 for 11 cycles, then out_valid=1, aluop=100.
REQ-034 SHALL cover: vector instr, no dsp_done, DSP_TIMEOUT=8 -> after 8 wait cycles out_illegal=1, FSM IDLE.
REQ-035 SHALL cover: flush concurrent with dsp_done in DSP_WAIT -> bubble, no completion; opcode 0x7F -> out_illegal=1.
REQ-036 SHALL cover: rst asserted mid-DSP_WAIT asynchronously -> all outputs 0 before next clk edge; build without CTRL_DSP_EN -> 1010111 illegal.

Source files
------------

// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Shared definitions for the ID-stage control decoder: opcode
//                constants, ALU-op encodings, DSP sequencer state encoding,
//                the registered control bundle and a small opcode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    // Major opcodes recognised by the decoder
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_VECTOR = 7'b1010111;

    // ALU operation classes handed to EX
    localparam logic [2:0] ALUOP_MEM = 3'b000;
    localparam logic [2:0] ALUOP_BR  = 3'b001;
    localparam logic [2:0] ALUOP_R   = 3'b010;
    localparam logic [2:0] ALUOP_I   = 3'b011;
    localparam logic [2:0] ALUOP_VEC = 3'b100;

    // DSP sequencer states
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DSP_START = 2'd1,
        ST_DSP_WAIT  = 2'd2
    } dsp_state_e;

    // ID/EX control bundle (destination register travels separately because
    // its width is a module parameter)
    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       alusrc;
        logic       memwrite;
        logic       memread;
        logic       branch;
        logic       memtoreg;
        logic       illegal;
        logic [2:0] aluop;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // Only R, S and B formats actually read rs2; for the others the rs2
    // field is immediate bits and must not trigger a load-use hazard.
    function automatic logic reads_rs2(input logic [6:0] opcode);
        return (opcode == OPC_RTYPE) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
    endfunction

endpackage : ctrl_pkg
`default_nettype wire

// File: rtl/ctrl_decode_comb.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_decode_comb
//  Description : Purely combinational opcode table. Maps the 7-bit major
//                opcode onto the ID/EX control bundle; unknown opcodes come
//                back as a valid, illegal bundle with every control low.
//  Ports       : opcode_i    - instruction bits [6:0]
//                ctrl_o      - decoded control bundle (valid always set)
//                is_vector_o - opcode is the vector/DSP opcode
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode_comb
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    output ctrl_t      ctrl_o,
    output logic       is_vector_o
);

    always_comb begin
        ctrl_o       = CTRL_BUBBLE;
        ctrl_o.valid = 1'b1;
        is_vector_o  = 1'b0;
        case (opcode_i)
            OPC_RTYPE: begin
                ctrl_o.regwrite = 1'b1;
                ctrl_o.aluop    = ALUOP_R;
            end
            OPC_ITYPE: begin
                ctrl_o.regwrite = 1'b1;
                ctrl_o.alusrc   = 1'b1;
                ctrl_o.aluop    = ALUOP_I;
            end
            OPC_LOAD: begin
                ctrl_o.regwrite = 1'b1;
                ctrl_o.alusrc   = 1'b1;
                ctrl_o.memread  = 1'b1;
                ctrl_o.memtoreg = 1'b1;
                ctrl_o.aluop    = ALUOP_MEM;
            end
            OPC_STORE: begin
                ctrl_o.alusrc   = 1'b1;
                ctrl_o.memwrite = 1'b1;
                ctrl_o.aluop    = ALUOP_MEM;
            end
            OPC_BRANCH: begin
                ctrl_o.branch   = 1'b1;
                ctrl_o.aluop    = ALUOP_BR;
            end
            OPC_VECTOR: begin
                is_vector_o     = 1'b1;
                ctrl_o.aluop    = ALUOP_VEC;
            end
            default: begin
                ctrl_o.illegal  = 1'b1;
            end
        endcase
    end

endmodule : ctrl_decode_comb
`default_nettype wire

// File: rtl/ctrl_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_decode_stage
//  Description : ID stage control decoder. Registers the decoded controls
//                into ID/EX, detects load-use hazards (stall + bubble),
//                honours branch flushes and, optionally, sequences a
//                multi-cycle DSP operation for the vector opcode.
//  Build macro : CTRL_DSP_EN - when defined, the vector opcode launches the
//                DSP sequencer (start pulse, wait with timeout, completion
//                write-back). When undefined the vector opcode is illegal,
//                dsp_start_o is tied low and stall comes from hazards only.
//  Ports       : clk, rst (async, active-high)
//                instr_valid_i, instr_i       - instruction in ID
//                flush_i                      - branch-taken kill from EX
//                ex_memread_i, ex_rd_i        - load in EX and its target
//                dsp_done_i / dsp_start_o     - DSP handshake
//                stall_o                      - hold PC and IF/ID (comb)
//                out_*_o                      - registered ID/EX controls
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode_stage
    import ctrl_pkg::*;
#(
    parameter int DSP_TIMEOUT = 64,
    parameter int RD_W        = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid_i,
    input  logic [31:0]     instr_i,
    input  logic            flush_i,
    input  logic            ex_memread_i,
    input  logic [RD_W-1:0] ex_rd_i,
    input  logic            dsp_done_i,
    output logic            dsp_start_o,
    output logic            stall_o,
    output logic            out_valid_o,
    output logic            out_regwrite_o,
    output logic            out_alusrc_o,
    output logic            out_memwrite_o,
    output logic            out_memread_o,
    output logic            out_branch_o,
    output logic            out_memtoreg_o,
    output logic            out_illegal_o,
    output logic [2:0]      out_aluop_o,
    output logic [RD_W-1:0] out_rd_o
);

    ctrl_t           w_dec;
    logic            w_is_vector;
    logic            w_hazard;
    logic            w_busy;
    logic [RD_W-1:0] w_rs1;
    logic [RD_W-1:0] w_rs2;
    logic [RD_W-1:0] w_rd;

    ctrl_t           ctrl_q, ctrl_d;
    logic [RD_W-1:0] rd_q,   rd_d;

    ctrl_decode_comb u_decode (
        .opcode_i    (instr_i[6:0]),
        .ctrl_o      (w_dec),
        .is_vector_o (w_is_vector)
    );

    assign w_rs1 = RD_W'(instr_i[19:15]);
    assign w_rs2 = RD_W'(instr_i[24:20]);
    assign w_rd  = RD_W'(instr_i[11:7]);

    assign w_hazard = instr_valid_i && ex_memread_i && (ex_rd_i != '0) &&
                      ((ex_rd_i == w_rs1) ||
                       ((ex_rd_i == w_rs2) && reads_rs2(instr_i[6:0])));

    // Reset also forces the combinational outputs low so that every output
    // reads zero while rst is high, not just after the next edge.
    assign stall_o = !rst && (w_hazard || w_busy);

`ifdef CTRL_DSP_EN
    localparam int CNT_W = $clog2(DSP_TIMEOUT + 1);

    dsp_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [RD_W-1:0] vrd_q,   vrd_d;
    logic            w_unused_bits;

    assign w_unused_bits = ^{instr_i[31:25], instr_i[14:12]};
    assign w_busy        = (state_q != ST_IDLE);
    assign dsp_start_o   = (state_q == ST_DSP_START);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vrd_d   = vrd_q;
        ctrl_d  = CTRL_BUBBLE;
        rd_d    = '0;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid_i && !flush_i && !w_hazard) begin
                    if (w_is_vector) begin
                        // Launch goes out as a bubble; the result is written
                        // back only when the DSP reports completion.
                        state_d = ST_DSP_START;
                        vrd_d   = w_rd;
                    end else begin
                        ctrl_d = w_dec;
                        rd_d   = w_dec.illegal ? '0 : w_rd;
                    end
                end
            end
            ST_DSP_START: begin
                cnt_d   = '0;
                state_d = flush_i ? ST_IDLE : ST_DSP_WAIT;
            end
            ST_DSP_WAIT: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (dsp_done_i) begin
                    // Completion wins over a coincident timeout.
                    state_d         = ST_IDLE;
                    cnt_d           = '0;
                    ctrl_d.valid    = 1'b1;
                    ctrl_d.regwrite = 1'b1;
                    ctrl_d.aluop    = ALUOP_VEC;
                    rd_d            = vrd_q;
                end else if (cnt_q == CNT_W'(DSP_TIMEOUT - 1)) begin
                    // This is the DSP_TIMEOUT-th wait cycle: abort.
                    state_d        = ST_IDLE;
                    cnt_d          = '0;
                    ctrl_d.valid   = 1'b1;
                    ctrl_d.illegal = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            vrd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vrd_q   <= vrd_d;
        end
    end
`else
    localparam int unused_dsp_timeout = DSP_TIMEOUT;

    logic w_unused_bits;

    assign w_unused_bits = ^{instr_i[31:25], instr_i[14:12], dsp_done_i};
    assign w_busy        = 1'b0;
    assign dsp_start_o   = 1'b0;

    always_comb begin
        ctrl_d = CTRL_BUBBLE;
        rd_d   = '0;
        if (instr_valid_i && !flush_i && !w_hazard) begin
            if (w_is_vector) begin
                ctrl_d.valid   = 1'b1;
                ctrl_d.illegal = 1'b1;
            end else begin
                ctrl_d = w_dec;
                rd_d   = w_dec.illegal ? '0 : w_rd;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= CTRL_BUBBLE;
            rd_q   <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            rd_q   <= rd_d;
        end
    end

    assign out_valid_o    = ctrl_q.valid;
    assign out_regwrite_o = ctrl_q.regwrite;
    assign out_alusrc_o   = ctrl_q.alusrc;
    assign out_memwrite_o = ctrl_q.memwrite;
    assign out_memread_o  = ctrl_q.memread;
    assign out_branch_o   = ctrl_q.branch;
    assign out_memtoreg_o = ctrl_q.memtoreg;
    assign out_illegal_o  = ctrl_q.illegal;
    assign out_aluop_o    = ctrl_q.aluop;
    assign out_rd_o       = rd_q;

endmodule : ctrl_decode_stage
`default_nettype wire
